seq_mult_datapath: RTL
======================

Name: seq_mult_datapath

Overview:
- Shift-add datapath for the 32-bit sequential multiplier; sits directly downstream of the multiplier FSM controller.
- Holds the multiplicand (MD) and multiplier (MR) registers and a result shift register (RS) with carry.
- Feeds MR back to the controller and executes its md_ld/mr_ld/rs_clear/rs_load/rs_shr strobes.
- Counts shifts, publishes the registered 2*WIDTH product with a done pulse, and flags controller protocol violations.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits; shift counter is $clog2(WIDTH)+1 bits.

Ports:
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  asynchronous active-low reset
- md_i  input  WIDTH  multiplicand operand
- mr_in_i  input  WIDTH  multiplier operand
- md_ld_i  input  1  capture md_i into MD
- mr_ld_i  input  1  capture mr_in_i into MR
- rs_clear_i  input  1  clear RS, carry, shift counter and status
- rs_load_i  input  1  accumulate: {carry, RS upper half} <= RS upper half + MD
- rs_shr_i  input  1  shift {carry, RS} right by one
- mr_o  output  WIDTH  MR register contents (to controller mr_i)
- product_o  output  2*WIDTH  registered final product
- product_valid_o  output  1  product_o holds a completed result (level)
- done_o  output  1  one-cycle pulse when the product is captured
- err_o  output  1  sticky protocol-error flag

Behaviour:
- Reset is asynchronous, applied on rst_n_i low: MD, MR, RS, carry, shift counter, product_o, product_valid_o, done_o and err_o all go to 0.
- MD and MR:
  - md_ld_i=1 gives MD<=md_i at the clock edge; mr_ld_i=1 gives MR<=mr_in_i. The two loads are independent.
  - mr_o = MR, driven directly with no extra latency. MR does not change during an operation.
- rs_clear_i has the highest priority. It sets RS<=0, carry<=0, cnt<=0, product_valid_o<=0 and err_o<=0. It may coincide with md_ld_i/mr_ld_i, which are still honoured.
- rs_load_i (when rs_clear_i=0):
  - {carry, RS[2W-1:W]} <= RS[2W-1:W] + MD, a W+1-bit sum.
  - RS[W-1:0] is unchanged.
- rs_shr_i (when rs_clear_i=0 and rs_load_i=0):
  - RS <= {carry, RS[2W-1:1]}, carry <= 0, cnt <= cnt+1.
- Completion:
  - Trigger: an rs_shr_i executes while cnt==WIDTH-1.
  - On that edge: product_o <= the shifted RS value, product_valid_o<=1, done_o<=1 for exactly one cycle.
  - product_o and product_valid_o then hold until the next rs_clear_i or reset.
- Protocol errors set err_o<=1 (sticky until rs_clear_i or reset) in either case:
  - rs_load_i and rs_shr_i asserted together. The load executes; the shift is dropped and cnt is not incremented.
  - rs_load_i or rs_shr_i asserted while cnt==WIDTH, i.e. after completion. RS, cnt and product_o stay unchanged.
- Reset mid-operation: all state clears immediately, no done_o, and product_valid_o reads 0.
- Latency:
  - One cycle per strobe.
  - With the controller, a full operation is 1 (load) + 32 to 64 (add/shift) cycles.
  - product_o is valid on the cycle after the 32nd shift edge.
- Arithmetic is unsigned. No overflow is possible: the final result fits in 2*WIDTH bits.
- Default next-state is hold for every register when no strobe is active.

Test Plan:
- Basic: md=7, mr=9; drive the controller-equivalent sequence (clear/load, then load+shift per set bit, shift only otherwise) -> after 32 shifts, product_o=63, done_o high for one cycle, product_valid_o=1, err_o=0.
- Carry path: md=0xFFFFFFFF, mr=0xFFFFFFFF -> product_o=0xFFFFFFFE00000001; the carry bit is exercised on every add.
- Zero and single-bit operands:
  - mr=0, md=0x12345678 -> product_o=0 with no rs_load pulses.
  - md=0x80000000, mr=0x3 -> product_o=0x0000000180000000.
- Protocol error:
  - rs_load_i and rs_shr_i high together at cnt=5 -> err_o=1, cnt stays 5, RS upper half = prior upper half + MD.
  - A 33rd rs_shr_i after completion -> err_o stays 1 and product_o is unchanged.
  - A subsequent rs_clear_i -> err_o=0 and product_valid_o=0.
- Reset mid-operation: assert rst_n_i low after 10 shifts -> all outputs read 0 asynchronously. A following full 5*6 operation gives product_o=30.
- Back-to-back: complete 3*4, then rs_clear_i with new operands 0x10000 * 0x10000 -> product_valid_o drops to 0 on the clear, then product_o=0x0000000100000000 with a single done_o pulse.

Source files
------------

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath for the sequential multiplier.
// Holds the multiplicand (MD), the multiplier (MR), the result shift register
// (RS) with its carry bit, and a shift counter. It executes the controller's
// strobes, publishes the registered product with a one-cycle done pulse, and
// latches a sticky error when the controller breaks the strobe protocol.
module seq_mult_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [WIDTH-1:0]   md_i,
  input  logic [WIDTH-1:0]   mr_in_i,
  input  logic               md_ld_i,
  input  logic               mr_ld_i,
  input  logic               rs_clear_i,
  input  logic               rs_load_i,
  input  logic               rs_shr_i,
  output logic [WIDTH-1:0]   mr_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic               product_valid_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  // Counter value at which the next shift completes the product.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  // Counter value once all WIDTH shifts have been performed.
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  // Architectural state.
  logic [WIDTH-1:0]   md_q;
  logic [WIDTH-1:0]   mr_q;
  logic [2*WIDTH-1:0] rs_q;
  logic               carry_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] product_q;
  logic               valid_q;
  logic               done_q;
  logic               err_q;

  // Next-state values.
  logic [2*WIDTH-1:0] rs_d;
  logic               carry_d;
  logic [CW-1:0]      cnt_d;
  logic [2*WIDTH-1:0] product_d;
  logic               valid_d;
  logic               done_d;
  logic               err_d;

  // Datapath helpers: the W+1-bit accumulate and the one-bit right shift.
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] rs_shifted;
  logic               finished;

  assign add_sum    = {1'b0, rs_q[2*WIDTH-1:WIDTH]} + {1'b0, md_q};
  assign rs_shifted = {carry_q, rs_q[2*WIDTH-1:1]};
  assign finished   = (cnt_q == CNT_FULL);

  // Operand registers: independent loads, held otherwise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: state is always written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n_i) begin
      md_q <= '0;
      mr_q <= '0;
    end else begin
      if (md_ld_i) md_q <= md_i;
      if (mr_ld_i) mr_q <= mr_in_i;
    end
  end

  // Strobe decode: clear > load > shift, with protocol checks.
  always_comb begin
    // NOTE: every output of this block gets a hold/default value first, so no
    // path through the decode can leave a signal unassigned and infer a latch.
    rs_d      = rs_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (rs_clear_i) begin
      rs_d      = '0;
      carry_d   = 1'b0;
      cnt_d     = '0;
      product_d = '0;
      valid_d   = 1'b0;
      err_d     = 1'b0;
    end else if ((rs_load_i || rs_shr_i) && finished) begin
      // Strobe after completion: flag it and leave the result untouched.
      err_d = 1'b1;
    end else if (rs_load_i) begin
      {carry_d, rs_d[2*WIDTH-1:WIDTH]} = add_sum;
      // A simultaneous shift is dropped and reported.
      if (rs_shr_i) err_d = 1'b1;
    end else if (rs_shr_i) begin
      rs_d    = rs_shifted;
      carry_d = 1'b0;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        product_d = rs_shifted;
        valid_d   = 1'b1;
        done_d    = 1'b1;
      end
    end
  end

  // Result/status register bank with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rs_q      <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rs_q      <= rs_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign mr_o            = mr_q;
  assign product_o       = product_q;
  assign product_valid_o = valid_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule
